// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// uart_tx_fifo_if
// Byte-push handshake and serial-line outputs of the UART transmit FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if;
    logic       in_en;
    logic [7:0] in_data;
    logic       in_busy;
    logic       txd;
    logic       tx_idle;

    modport master (
        output in_en,
        output in_data,
        input  in_busy,
        input  txd,
        input  tx_idle
    );

    modport slave (
        input  in_en,
        input  in_data,
        output in_busy,
        output txd,
        output tx_idle
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo
// Byte FIFO feeding an 8N1 UART serializer; define UART_TX_PARITY_EN to
// insert an even-parity bit between the data bits and the stop bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [7:0]       head_byte;

    // Fullness comes from the registered count, so a same-cycle pop never
    // makes room for a same-cycle push.
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = bus.in_en && !fifo_full;
    assign head_byte  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              txd_q;
    logic              tx_idle_q;
    logic              bit_done;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    assign bit_done = (baud_q == BAUD_LAST);

    // Popping straight out of a finishing STOP keeps frames gap-free.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            tx_idle_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            tx_idle_q <= (state_q == S_IDLE) && fifo_empty;

            // Line level trails the state by one register stage.
            case (state_q)
                S_START:  txd_q <= 1'b0;
                S_DATA:   txd_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY: txd_q <= par_q;
`endif
                default:  txd_q <= 1'b1;
            endcase

            if (pop) begin
                state_q <= S_START;
                baud_q  <= '0;
                bit_q   <= '0;
                shift_q <= head_byte;
`ifdef UART_TX_PARITY_EN
                par_q   <= ^head_byte;
`endif
            end else if (state_q != S_IDLE) begin
                if (!bit_done) begin
                    baud_q <= baud_q + 1'b1;
                end else begin
                    baud_q <= '0;
                    case (state_q)
                        S_START: state_q <= S_DATA;
                        S_DATA: begin
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: state_q <= S_STOP;
`endif
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.in_busy = fifo_full;
    assign bus.txd     = txd_q;
    assign bus.tx_idle = tx_idle_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo
// Directed and random checks of uart_tx_fifo against a frame-schedule model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit HAS_PAR    = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit HAS_PAR    = 1'b0;
`endif
    localparam int FRAMECYC = FRAME_BITS * CPB;
    localparam int LOG_N    = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Each accepted byte: acceptance edge, pop edge, data.
    typedef struct {
        int         a;
        int         s;
        logic [7:0] d;
    } rec_t;

    rec_t q[$];
    int   t      = 0;
    int   errors = 0;
    int   checks = 0;
    logic txd_log  [LOG_N];
    logic idle_log [LOG_N];

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int cnt_before(input int tt);
        int n = 0;
        foreach (q[i]) begin
            if (q[i].a < tt) n++;
            if (q[i].s < tt) n--;
        end
        return n;
    endfunction

    function automatic int cnt_after(input int tt);
        int n = 0;
        foreach (q[i]) begin
            if (q[i].a <= tt) n++;
            if (q[i].s <= tt) n--;
        end
        return n;
    endfunction

    // Line level after edge tt: the start bit leaves one edge after the pop.
    function automatic logic exp_txd(input int tt);
        logic v = 1'b1;
        foreach (q[i]) begin
            int rel = tt - (q[i].s + 1);
            if (rel >= 0 && rel < FRAMECYC) begin
                int b = rel / CPB;
                if (b == 0)                   v = 1'b0;
                else if (b <= 8)              v = q[i].d[b-1];
                else if (HAS_PAR && b == 9)   v = ^q[i].d;
                else                          v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_idle(input int tt);
        logic v = 1'b1;
        foreach (q[i]) begin
            if (tt >= q[i].a + 1 && tt < q[i].s + 1 + FRAMECYC) v = 1'b0;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic step();
        rec_t r;
        @(posedge clk);
        t++;
        if (rst_n && bus.in_en && cnt_before(t) < DEPTH) begin
            r.a = t;
            r.s = (q.size() == 0) ? t + 1 : imax(t + 1, q[q.size()-1].s + FRAMECYC);
            r.d = bus.in_data;
            q.push_back(r);
        end
        #1;
        if (t < LOG_N) begin
            txd_log[t]  = bus.txd;
            idle_log[t] = bus.tx_idle;
        end
        if (!rst_n) begin
            chk("rst_txd",     bus.txd,     1'b1);
            chk("rst_tx_idle", bus.tx_idle, 1'b1);
            chk("rst_in_busy", bus.in_busy, 1'b0);
        end else begin
            chk("txd",     bus.txd,     exp_txd(t));
            chk("tx_idle", bus.tx_idle, exp_idle(t));
            chk("in_busy", bus.in_busy, (cnt_after(t) == DEPTH));
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_en   = 1'b1;
        bus.in_data = b;
        step();
        bus.in_en   = 1'b0;
    endtask

    task automatic drain();
        int end_t = t;
        bus.in_en = 1'b0;
        foreach (q[i]) end_t = imax(end_t, q[i].s + 1 + FRAMECYC);
        for (int i = 0; i < 5000 && t < end_t + 3; i++) step();
    endtask

    initial begin
        int t0, t1, tp, tr, t5;
        bus.in_en   = 1'b0;
        bus.in_data = 8'h00;

        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single byte 0x41: bits 1,0,0,0,0,0,1,0
        send(8'h41);
        t0 = t;
        drain();
        chk("r26_pre_start", txd_log[t0+1],  1'b1);
        chk("r26_start_lo",  txd_log[t0+2],  1'b0);
        chk("r26_start_end", txd_log[t0+5],  1'b0);
        chk("r26_bit0",      txd_log[t0+6],  1'b1);
        chk("r26_bit1",      txd_log[t0+10], 1'b0);
        chk("r26_bit6",      txd_log[t0+30], 1'b1);
        chk("r26_bit7",      txd_log[t0+34], 1'b0);
        chk("r26_stop",      txd_log[t0+38], 1'b1);
        chk("r26_idle_lo",   idle_log[t0+1], 1'b0);
        chk("r26_idle_late", idle_log[t0+1+FRAMECYC], 1'b0);
        chk("r26_idle_hi",   idle_log[t0+2+FRAMECYC], 1'b1);

        // "1","2","\n" on consecutive cycles -> contiguous frames
        bus.in_en = 1'b1;
        bus.in_data = 8'h31; step();
        t1 = t;
        bus.in_data = 8'h32; step();
        bus.in_data = 8'h0A; step();
        drain();
        chk("r27_f1_start", txd_log[t1+2], 1'b0);
        chk("r27_f1_stop",  txd_log[t1+1+FRAMECYC], 1'b1);
        chk("r27_f2_start", txd_log[t1+2+FRAMECYC], 1'b0);
        chk("r27_f3_start", txd_log[t1+2+2*FRAMECYC], 1'b0);

        // Continuous offers for 20 cycles: FIFO fills and holds off upstream
        bus.in_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 8'(8'hA0 + i);
            step();
        end
        chk("r28_busy_end", bus.in_busy, 1'b1);
        drain();

        // Parity / frame length
        bus.in_en = 1'b1;
        bus.in_data = 8'h03; step();
        tp = t;
        bus.in_data = 8'h07; step();
        drain();
`ifdef UART_TX_PARITY_EN
        chk("r30_par_03", txd_log[tp+2+9*CPB], 1'b0);
        chk("r30_par_07", txd_log[tp+2+FRAMECYC+9*CPB], 1'b1);
`else
        chk("r30_stop_03", txd_log[tp+2+9*CPB], 1'b1);
        chk("r30_stop_07", txd_log[tp+2+FRAMECYC+9*CPB], 1'b1);
`endif
        chk("r30_f1_last", txd_log[tp+1+FRAMECYC], 1'b1);
        chk("r30_f2_start", txd_log[tp+2+FRAMECYC], 1'b0);

        // Reset during data bit 3 of 0xFF with five more bytes queued
        bus.in_en = 1'b1;
        bus.in_data = 8'hFF; step();
        tr = t;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'(8'h10 + i);
            step();
        end
        bus.in_en = 1'b0;
        for (int i = 0; i < 100 && t < tr + 19; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("r29_txd_now",  bus.txd,     1'b1);
        chk("r29_idle_now", bus.tx_idle, 1'b1);
        chk("r29_busy_now", bus.in_busy, 1'b0);
        q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        send(8'h55);
        t5 = t;
        drain();
        chk("r29_55_start", txd_log[t5+2],  1'b0);
        chk("r29_55_bit0",  txd_log[t5+6],  1'b1);
        chk("r29_55_bit1",  txd_log[t5+10], 1'b0);
        chk("r29_55_bit7",  txd_log[t5+34], 1'b0);
        repeat (50) step();

        // Random offers, frequently hitting a full FIFO
        for (int i = 0; i < 300; i++) begin
            bus.in_en   = ($urandom_range(0, 2) == 0);
            bus.in_data = 8'($urandom);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the byte FIFO depth; power of two, minimum 2.
REQ-003 clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  the reset; asynchronous and active-low.
REQ-005 in_en  input  1  upstream has a byte on in_data to enqueue.
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_busy  output  1  FIFO full; a byte offered while high is not accepted.
REQ-008 txd  output  1  UART serial line, idle high.
REQ-009 tx_idle  output  1  high when the FIFO is empty and the serializer is in IDLE.

Function
REQ-010 A byte SHALL be accepted on a rising edge where in_en=1 and in_busy=0; with in_en=1 and in_busy=1 nothing SHALL be written, and upstream holds the byte.
REQ-011 in_busy SHALL equal (count == FIFO_DEPTH), taken from the registered count; a pop in the same cycle SHALL NOT free a slot for that cycle's push.
REQ-012 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 Bytes SHALL leave on txd in acceptance order; none SHALL be dropped or duplicated.
REQ-014 Serializer states: IDLE, START, DATA, STOP (plus PARITY per REQ-024).
REQ-015 IDLE transition: when count>0, the serializer SHALL pop the head byte into the shift register and enter START.
REQ-016 START holds txd=0, DATA shifts bits 0..7 LSB first, and STOP holds txd=1.
REQ-017 Every bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT) and a 3-bit bit counter.
REQ-018 At the end of STOP, the serializer SHALL go to IDLE.
REQ-019 When the FIFO is non-empty at the end of STOP, the next START bit SHALL begin on the immediately following cycle; back-to-back frames have no gap (10*CLKS_PER_BIT cycles per byte).
REQ-020 txd SHALL be driven from a register, glitch-free.
REQ-021 Latency: a byte accepted into an empty, idle block at edge N SHALL make txd fall at edge N+2.
REQ-022 tx_idle SHALL fall on the edge after the first acceptance and rise on the edge where STOP of the last queued byte completes.

Reset
REQ-023 With rst_n=0, regardless of clock, all of the following SHALL hold: txd=1, in_busy=0, tx_idle=1, FIFO count and pointers=0, state=IDLE, counters=0; reset mid-frame SHALL abort the frame, and after release no partial frame or stale byte SHALL be emitted.

Configuration
REQ-024 Macro UART_TX_PARITY_EN, when defined, SHALL add a PARITY state between DATA and STOP transmitting even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; a frame is then 11 bits long.
REQ-025 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and frames SHALL be 8N1 (10 bits).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=16 unless stated)
REQ-026 Single byte 0x41 accepted at edge 0 -> txd low edges 2..5, then bits 1,0,0,0,0,0,1,0 for 4 clocks each, then high for 4 clocks; tx_idle=1 at edge 42.
REQ-027 "1","2","\n" on three consecutive cycles -> three contiguous frames (0x31, 0x32, 0x0A) in 120 cycles with no idle bit between them; in_busy never high.
REQ-028 in_en held high with a new byte each cycle for 20 cycles -> exactly 17 bytes accepted, in_busy high from edge 17, and all 17 appear on txd in order.
REQ-029 rst_n pulsed low during data bit 3 of 0xFF with 5 bytes queued -> txd=1 and tx_idle=1 immediately; after release, 0x55 alone is transmitted correctly.
REQ-030 With UART_TX_PARITY_EN defined, bytes 0x03 and 0x07 -> parity bits 0 and 1 respectively, frames 44 cycles each; without the macro the same bytes give 40-cycle frames.
